des_key_schedule: RTL
=====================

Name: des_key_schedule

Overview:
- Sequential DES key-schedule generator.
- Accepts a 64-bit key, applies PC-1, then produces the 16 round subkeys one per handshake. Each subkey is PC-2 of the current rotated C/D halves.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1).
- Optional per-byte odd-parity check on the key.
- Sits between the key register and the Feistel round datapath; replaces a precomputed key table.

Parameters:
- SHIFT_SCHED, 16'b1100_0000_1000_0001: per-round rotate amount, MSB = round 1; bit=1 means rotate by 1, bit=0 means rotate by 2. The sum of all rotates must be 28, otherwise decrypt output is undefined.
- PARITY_CHECK, 1: 1 = reject keys with any even-parity byte; 0 = ignore parity bits.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- key_i  in  [1:64]  DES key, bit 1 = MSB; bits 8,16,..,64 are parity bits.
- decrypt_i  in  1  sampled with key: 0 = K1 first, 1 = K16 first.
- key_valid_i  in  1  key offer.
- key_ready_o  out  1  block can accept a key.
- abort_i  in  1  drop current schedule, return to IDLE.
- subkey_o  out  [1:48]  current round subkey.
- subkey_valid_o  out  1  subkey_o valid.
- subkey_ready_i  in  1  consumer accepts subkey_o.
- round_o  out  4  DES round index of subkey_o, 0 = round 1 .. 15 = round 16.
- last_o  out  1  subkey_o is the final subkey of this schedule.
- key_err_o  out  1  one-cycle pulse: key rejected for parity.

Behaviour:
- Reset (rst_n_i low at a clock edge) gives:
  - state = IDLE
  - key_ready_o = 1, subkey_valid_o = 0
  - subkey_o = 0, round_o = 0, last_o = 0
  - key_err_o = 0
  - internal C, D and counter = 0
- Reset mid-schedule discards all state; no further subkeys are emitted.
- States:
  - IDLE: key_ready_o = 1.
  - RUN: subkey_valid_o = 1.
  - ERR: one cycle; key_err_o = 1, key_ready_o = 0.
- IDLE, key accepted (key_valid_i & key_ready_o) at edge T:
  - C0 = PC-1 left half, D0 = PC-1 right half (28 bits each).
  - If PARITY_CHECK = 1 and any key byte has even parity: go to ERR. key_err_o = 1 during cycle T+1, then IDLE. No subkeys are produced.
  - Otherwise latch decrypt_i and go to RUN. The first subkey is valid in cycle T+1 (latency 1).
- Encrypt:
  - C/D for round n = left rotation by SHIFT_SCHED[n] amount applied to round n-1 values.
  - First subkey = PC-2(rotl(C0,D0, shift1)).
  - round_o counts 0 up to 15.
- Decrypt:
  - First subkey = PC-2(C0,D0), which equals K16; round_o = 15.
  - After each handshake, C/D rotate right by the amount of the round just emitted (16, 15, .., 2), then the subkey is output.
  - round_o counts 15 down to 0.
- Handshake:
  - subkey_o, round_o and last_o are held stable while subkey_valid_o & !subkey_ready_i.
  - The subkey advances on the edge where valid & ready; the next subkey appears the following cycle, so back-to-back rate is 1 per cycle.
- last_o = 1 exactly when 16 subkeys have been presented, i.e. the 16th subkey is on subkey_o.
- Last subkey handshake at edge E: subkey_valid_o = 0 and key_ready_o = 1 from E+1 onward. No new key can be accepted in the same cycle as the last handshake.
- abort_i in RUN:
  - Goes to IDLE next edge and drops all remaining subkeys.
  - abort_i has priority over a simultaneous subkey handshake.
  - In IDLE, abort_i is ignored.
- key_valid_i is ignored while key_ready_o = 0.
- The subkey path is combinational PC-2 from registered C/D; subkey_o is driven 0 outside RUN.

Test Plan:
- Encrypt, key 0x133457799BBCDFF1, subkey_ready_i tied 1:
  - first subkey at T+1 is 0x1B02EFFC7072, round_o = 0.
  - 16th subkey is 0xCB3D8B0E17F5 with last_o = 1.
  - key_ready_o = 1 on the following cycle.
- Decrypt, same key:
  - first subkey is 0xCB3D8B0E17F5 with round_o = 15.
  - last subkey is 0x1B02EFFC7072 with round_o = 0 and last_o = 1.
- Backpressure, encrypt: hold subkey_ready_i = 0 for 5 cycles at round 3 → subkey_o and round_o = 2 stay constant; the sequence resumes without skipping any subkey.
- Parity error:
  - PARITY_CHECK = 1, key 0x0000000000000000 → key_err_o pulses for 1 cycle at T+1, subkey_valid_o stays 0, key_ready_o = 1 at T+2.
  - PARITY_CHECK = 0, same key → 16 subkeys, all 0x000000000000.
- Abort with a simultaneous handshake at round 7 → next cycle subkey_valid_o = 0 and key_ready_o = 1. A new key accepted afterwards restarts at round_o = 0.
- Reset asserted at round 10 → next cycle all outputs at reset values; no stray subkey_valid_o after reset is released.

Source files
------------

// File: rtl/des_key_schedule.sv
// ---------------------------------------------------------------------------
// des_key_schedule
//
// Sequential DES key-schedule generator. A 64-bit key is taken through PC-1
// into two 28-bit halves (C, D). One round subkey is then presented per
// valid/ready handshake as PC-2 of the current C/D. Encrypt order walks
// K1..K16 with left rotations; decrypt order starts from C0/D0 (which equals
// the round-16 state, since the rotations sum to 28) and walks K16..K1 with
// right rotations. Keys may optionally be rejected for bad byte parity.
//
// Ports
//   clk_i          clock, rising edge
//   rst_n_i        synchronous active-low reset
//   key_i[63:0]    DES key; key_i[63] is DES bit 1, key_i[0] is DES bit 64.
//                  Bits 8,16,..,64 (key_i[56],..,key_i[0]) are parity bits.
//   decrypt_i      sampled with the key: 0 = K1 first, 1 = K16 first
//   key_valid_i    key offer
//   key_ready_o    block can accept a key (IDLE)
//   abort_i        drop the running schedule and return to IDLE
//   subkey_o[47:0] current subkey; subkey_o[47] is DES subkey bit 1
//   subkey_valid_o subkey_o is valid
//   subkey_ready_i consumer accepts subkey_o
//   round_o[3:0]   DES round of subkey_o, 0 = round 1 .. 15 = round 16
//   last_o         subkey_o is the 16th subkey of this schedule
//   key_err_o      one-cycle pulse: key rejected for parity
// ---------------------------------------------------------------------------
module des_key_schedule #(
  // MSB = round 1; 1 = rotate by one, 0 = rotate by two.
  parameter logic [15:0] SHIFT_SCHED  = 16'b1100_0000_1000_0001,
  parameter bit          PARITY_CHECK = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  input  logic        abort_i,
  output logic [47:0] subkey_o,
  output logic        subkey_valid_o,
  input  logic        subkey_ready_i,
  output logic [3:0]  round_o,
  output logic        last_o,
  output logic        key_err_o
);

  // DES tables, 1-based DES bit numbers.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t      state_reg;
  logic [27:0] c_reg;
  logic [27:0] d_reg;
  logic [3:0]  round_reg;
  logic [3:0]  count_reg;    // subkeys already handed over in this schedule
  logic        decrypt_reg;

  // ---- PC-1 on the incoming key --------------------------------------------
  // Vector bit 55-gi holds DES position gi+1 of the 56-bit C||D string.
  logic [55:0] pc1_cd;
  logic [27:0] c0;
  logic [27:0] d0;

  for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
    assign pc1_cd[55-gi] = key_i[64-PC1[gi]];
  end

  assign c0 = pc1_cd[55:28];
  assign d0 = pc1_cd[27:0];

  // ---- byte parity ---------------------------------------------------------
  logic [7:0] byte_odd;
  logic       parity_bad;

  for (genvar gi = 0; gi < 8; gi++) begin : g_parity
    assign byte_odd[gi] = ^key_i[8*gi +: 8];
  end

  assign parity_bad = ~&byte_odd;

  // ---- PC-2 on the registered halves ---------------------------------------
  logic [55:0] cd_cur;
  logic [47:0] subkey_raw;

  assign cd_cur = {c_reg, d_reg};

  for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
    assign subkey_raw[47-gi] = cd_cur[56-PC2[gi]];
  end

  assign subkey_o = (state_reg == RUN) ? subkey_raw : 48'd0;
  assign round_o  = round_reg;

  // ---- rotate amounts --------------------------------------------------------
  // Round index r selects SHIFT_SCHED[15-r], i.e. SHIFT_SCHED[~r] for 4 bits.
  logic [3:0] round_inc;
  logic       shift_cur_one;   // rotate amount of the round on subkey_o
  logic       shift_nxt_one;   // rotate amount of the following round
  logic       shift_first_one; // rotate amount of round 1

  assign round_inc       = round_reg + 4'd1;
  assign shift_cur_one   = SHIFT_SCHED[~round_reg];
  assign shift_nxt_one   = SHIFT_SCHED[~round_inc];
  assign shift_first_one = SHIFT_SCHED[15];

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic by_one);
    return by_one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic by_one);
    return by_one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  // ---- control -------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg      <= IDLE;
      c_reg          <= 28'd0;
      d_reg          <= 28'd0;
      round_reg      <= 4'd0;
      count_reg      <= 4'd0;
      decrypt_reg    <= 1'b0;
      key_ready_o    <= 1'b1;
      subkey_valid_o <= 1'b0;
      last_o         <= 1'b0;
      key_err_o      <= 1'b0;
    end else begin
      key_err_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (key_valid_i && key_ready_o) begin
            key_ready_o <= 1'b0;
            if (PARITY_CHECK && parity_bad) begin
              state_reg <= ERR;
              key_err_o <= 1'b1;
            end else begin
              state_reg      <= RUN;
              subkey_valid_o <= 1'b1;
              decrypt_reg    <= decrypt_i;
              count_reg      <= 4'd0;
              last_o         <= 1'b0;
              if (decrypt_i) begin
                // C0/D0 already is the round-16 state.
                c_reg     <= c0;
                d_reg     <= d0;
                round_reg <= 4'd15;
              end else begin
                c_reg     <= rotl(c0, shift_first_one);
                d_reg     <= rotl(d0, shift_first_one);
                round_reg <= 4'd0;
              end
            end
          end
        end

        ERR: begin
          state_reg   <= IDLE;
          key_ready_o <= 1'b1;
        end

        RUN: begin
          // abort wins over a handshake in the same cycle.
          if (abort_i || (subkey_ready_i && count_reg == 4'd15)) begin
            state_reg      <= IDLE;
            key_ready_o    <= 1'b1;
            subkey_valid_o <= 1'b0;
            round_reg      <= 4'd0;
            last_o         <= 1'b0;
          end else if (subkey_ready_i) begin
            count_reg <= count_reg + 4'd1;
            last_o    <= (count_reg == 4'd14);
            if (decrypt_reg) begin
              // Undo the rotation of the round just emitted.
              c_reg     <= rotr(c_reg, shift_cur_one);
              d_reg     <= rotr(d_reg, shift_cur_one);
              round_reg <= round_reg - 4'd1;
            end else begin
              c_reg     <= rotl(c_reg, shift_nxt_one);
              d_reg     <= rotl(d_reg, shift_nxt_one);
              round_reg <= round_inc;
            end
          end
        end

        default: begin
          state_reg      <= IDLE;
          key_ready_o    <= 1'b1;
          subkey_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
